// File: rtl/cache_fill_controller_if.sv
// cache_fill_controller_if: CPU handshake, datapath strobes and statistics for the fill controller
interface cache_fill_controller_if #(
    parameter int ADDR_W   = 15,
    parameter int OFFSET_W = 2,
    parameter int CNT_W    = 16
);
    logic                start;
    logic [ADDR_W-1:0]   address;
    logic                hit;
    logic                mem_ack;
    logic [ADDR_W-1:0]   addr_reg;
    logic                cache_read;
    logic                cache_write;
    logic                valid_set;
    logic [OFFSET_W-1:0] fill_offset;
    logic                mem_read;
    logic [ADDR_W-1:0]   mem_addr;
    logic                ready;
    logic [CNT_W-1:0]    access_count;
    logic [CNT_W-1:0]    hit_count;

    modport master (
        input  start, address, hit, mem_ack,
        output addr_reg, cache_read, cache_write, valid_set, fill_offset,
               mem_read, mem_addr, ready, access_count, hit_count
    );

    modport slave (
        output start, address, hit, mem_ack,
        input  addr_reg, cache_read, cache_write, valid_set, fill_offset,
               mem_read, mem_addr, ready, access_count, hit_count
    );
endinterface

// File: rtl/cache_fill_controller.sv
// cache_fill_controller: lookup / block-fill / reread sequencer for a direct-mapped cache
// Optional statistics counters enabled by defining CACHE_FILL_STATS_EN.
module cache_fill_controller #(
    parameter int ADDR_W   = 15,
    parameter int OFFSET_W = 2,
    parameter int CNT_W    = 16
) (
    input logic clk,
    input logic rst,
    cache_fill_controller_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_FILL, S_REREAD} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [OFFSET_W-1:0] r_fill;
    logic                w_write;
    logic                w_last;

    assign w_write = (r_state == S_FILL) && bus.mem_ack;
    assign w_last  = w_write && (&r_fill);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // next-state: a fill only ends on the ack of the last word in the block
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = bus.start ? S_LOOKUP : S_IDLE;
            S_LOOKUP: w_next = bus.hit ? S_IDLE : S_FILL;
            S_FILL:   w_next = w_last ? S_REREAD : S_FILL;
            default:  w_next = S_IDLE;
        endcase
    end

    // outputs: state-decoded strobes plus Mealy write/valid on mem_ack
    always_comb begin
        bus.ready       = r_state == S_IDLE;
        bus.cache_read  = (r_state == S_LOOKUP) || (r_state == S_REREAD);
        bus.mem_read    = r_state == S_FILL;
        bus.cache_write = w_write;
        bus.valid_set   = w_last;
        bus.addr_reg    = r_addr;
        bus.fill_offset = r_fill;
        bus.mem_addr    = {r_addr[ADDR_W-1:OFFSET_W], r_fill};
    end

    // address latch and fill word counter; counter wraps to 0 after the last word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_fill <= '0;
        end else begin
            if (r_state == S_IDLE && bus.start) r_addr <= bus.address;
            if (r_state == S_LOOKUP && !bus.hit) r_fill <= '0;
            else if (w_write)                    r_fill <= r_fill + 1'b1;
        end
    end

`ifdef CACHE_FILL_STATS_EN
    logic [CNT_W-1:0] r_access;
    logic [CNT_W-1:0] r_hits;

    // saturating lookup and first-lookup hit counters; REREAD is not a lookup
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_access <= '0;
            r_hits   <= '0;
        end else if (r_state == S_LOOKUP) begin
            r_access <= (&r_access) ? r_access : r_access + 1'b1;
            if (bus.hit) r_hits <= (&r_hits) ? r_hits : r_hits + 1'b1;
        end
    end

    assign bus.access_count = r_access;
    assign bus.hit_count    = r_hits;
`else
    assign bus.access_count = '0;
    assign bus.hit_count    = '0;
`endif
endmodule

// File: tb/tb_cache_fill_controller.sv
// tb_cache_fill_controller: directed checks of hit, miss fill, busy ignore, mid-fill reset and stats
module tb_cache_fill_controller;
`ifdef CACHE_FILL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    cache_fill_controller_if #(.ADDR_W(15), .OFFSET_W(2), .CNT_W(16)) bus ();
    cache_fill_controller_if #(.ADDR_W(15), .OFFSET_W(2), .CNT_W(2))  sat ();

    cache_fill_controller #(.ADDR_W(15), .OFFSET_W(2), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .bus(bus.master)
    );
    cache_fill_controller #(.ADDR_W(15), .OFFSET_W(2), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .bus(sat.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic stats(input string tag, input int acc, input int hits);
        check({tag, "_access"}, 32'(bus.access_count), STATS ? 32'(acc) : 32'd0);
        check({tag, "_hits"}, 32'(bus.hit_count), STATS ? 32'(hits) : 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 0; bus.address = '0; bus.hit = 0; bus.mem_ack = 0;
        sat.start = 0; sat.address = '0; sat.hit = 1; sat.mem_ack = 0;
        #1;
        check("rst_ready", 32'(bus.ready), 1);
        check("rst_strobes", {bus.cache_read, bus.cache_write, bus.valid_set, bus.mem_read}, 0);
        check("rst_addr", 32'(bus.addr_reg), 0);
        stats("rst", 0, 0);
        @(negedge clk); rst = 1'b0;

        // hit access
        @(negedge clk); bus.start = 1; bus.address = 15'h1234; bus.hit = 1;
        #1 check("hit_idle_ready", 32'(bus.ready), 1);
        @(negedge clk); bus.start = 0;
        #1 check("hit_c1_read", 32'(bus.cache_read), 1);
        check("hit_c1_ready", 32'(bus.ready), 0);
        check("hit_addr", 32'(bus.addr_reg), 32'h1234);
        check("hit_no_memread", 32'(bus.mem_read), 0);
        @(negedge clk);
        #1 check("hit_c2_ready", 32'(bus.ready), 1);
        check("hit_c2_read", 32'(bus.cache_read), 0);
        stats("hit", 1, 1);

        // miss with two wait cycles per word, plus a stray start during FILL
        @(negedge clk); bus.start = 1; bus.address = 15'h1234; bus.hit = 0;
        @(negedge clk); bus.start = 0;
        #1 check("miss_lookup_read", 32'(bus.cache_read), 1);
        for (int w = 0; w < 4; w++) begin
            for (int n = 0; n < 2; n++) begin
                @(negedge clk); bus.mem_ack = 0;
                bus.start = (w == 1 && n == 0);
                if (bus.start) bus.address = 15'h0ABC;
                #1 check("miss_wait_wr", 32'(bus.cache_write), 0);
                check("miss_wait_vs", 32'(bus.valid_set), 0);
                check("miss_memread", 32'(bus.mem_read), 1);
                check("miss_wait_addr", 32'(bus.mem_addr), 32'h1234 + w);
            end
            @(negedge clk); bus.start = 0; bus.mem_ack = 1;
            #1 check("miss_ack_wr", 32'(bus.cache_write), 1);
            check("miss_ack_vs", 32'(bus.valid_set), w == 3);
            check("miss_ack_addr", 32'(bus.mem_addr), 32'h1234 + w);
        end
        @(negedge clk); bus.mem_ack = 0;
        #1 check("reread_read", 32'(bus.cache_read), 1);
        check("reread_ready", 32'(bus.ready), 0);
        check("reread_memread", 32'(bus.mem_read), 0);
        check("busy_addr_kept", 32'(bus.addr_reg), 32'h1234);
        @(negedge clk);
        #1 check("miss_done_ready", 32'(bus.ready), 1);
        check("miss_done_read", 32'(bus.cache_read), 0);
        stats("miss", 2, 1);
        @(negedge clk); bus.mem_ack = 1;
        #1 check("idle_ack_wr", 32'(bus.cache_write), 0);
        check("idle_ack_memread", 32'(bus.mem_read), 0);
        check("no_extra_lookup", 32'(bus.cache_read), 0);

        // reset after the second fill write
        @(negedge clk); bus.mem_ack = 0; bus.start = 1; bus.address = 15'h7FFF;
        @(negedge clk); bus.start = 0;
        for (int w = 0; w < 2; w++) begin
            @(negedge clk); bus.mem_ack = 1;
            #1 check("top_addr", 32'(bus.mem_addr), 32'h7FFC + w);
            check("mid_wr", 32'(bus.cache_write), 1);
            check("mid_vs", 32'(bus.valid_set), 0);
        end
        @(negedge clk); bus.mem_ack = 0;
        #1 check("mid_offset", 32'(bus.fill_offset), 2);
        check("mid_memread", 32'(bus.mem_read), 1);
        #1 rst = 1'b1; bus.start = 1;
        #1 check("rst_fill_memread", 32'(bus.mem_read), 0);
        check("rst_fill_ready", 32'(bus.ready), 1);
        check("rst_fill_vs", 32'(bus.valid_set), 0);
        check("rst_fill_offset", 32'(bus.fill_offset), 0);
        @(negedge clk); rst = 1'b0; bus.start = 0;
        #1 check("rst_start_ignored", 32'(bus.ready), 1);
        stats("rst_fill", 0, 0);

        // next access restarts the fill at offset 0, one word per cycle
        @(negedge clk); bus.start = 1; bus.address = 15'h0ABC;
        @(negedge clk); bus.start = 0;
        for (int w = 0; w < 4; w++) begin
            @(negedge clk); bus.mem_ack = 1;
            #1 check("refill_offset", 32'(bus.fill_offset), w);
            check("refill_addr", 32'(bus.mem_addr), 32'h0ABC + w);
            check("refill_vs", 32'(bus.valid_set), w == 3);
        end
        @(negedge clk); bus.mem_ack = 0;
        #1 check("refill_reread", 32'(bus.cache_read), 1);
        @(negedge clk);
        #1 check("refill_ready", 32'(bus.ready), 1);
        stats("refill", 1, 0);

        // saturation on the narrow-counter instance
        for (int a = 0; a < 5; a++) begin
            @(negedge clk); sat.start = 1;
            @(negedge clk); sat.start = 0;
        end
        @(negedge clk);
        #1 check("sat_access", 32'(sat.access_count), STATS ? 32'd3 : 32'd0);
        check("sat_hits", 32'(sat.hit_count), STATS ? 32'd3 : 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
